// File: rtl/apb_master_nsel.sv
// apb_master_nsel: APB master with NUM_SLAVES decoded PSEL lines, back-to-back transfers, wait-state timeout, decode-error reporting; optional byte strobes under APB_PSTRB_EN
module apb_master_nsel #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_BITS   = 2,
  parameter int TOUT_CYC   = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [ADDR_WIDTH-1:0]            ADDR_mst_i,
  input  logic                             RW_mst_i,
  input  logic                             TRANSFER_mst_i,
  input  logic [DATA_WIDTH-1:0]            WDATA_mst_i,
  input  logic                             TOUT_mst_i,
  output logic                             BUSY_mst_o,
  output logic                             DONE_mst_o,
  output logic [1:0]                       FAIL_mst_o,
  output logic [DATA_WIDTH-1:0]            RDATA_mst_o,
  output logic [ADDR_WIDTH-1:0]            PADDR_mst_o,
  output logic                             PWRITE_mst_o,
  output logic [NUM_SLAVES-1:0]            PSEL_mst_o,
  output logic                             PENABLE_mst_o,
  output logic [DATA_WIDTH-1:0]            PWDATA_mst_o,
  input  logic [NUM_SLAVES-1:0]            PREADY_mst_i,
  input  logic [NUM_SLAVES-1:0]            PSLVERR_mst_i,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]          STRB_mst_i,
  output logic [DATA_WIDTH/8-1:0]          PSTRB_mst_o,
`endif
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA_mst_i
);
  localparam int CW = $clog2(TOUT_CYC + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2, S_ERR = 2'd3;
  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_err_late;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [SEL_BITS-1:0]   w_idx;
  logic                  w_valid, w_ready, w_slverr, w_access, w_complete, w_abort, w_accept;
  assign w_idx      = ADDR_mst_i[ADDR_WIDTH-1 -: SEL_BITS];
  assign w_valid    = 32'(w_idx) < NUM_SLAVES;
  assign w_ready    = |(PREADY_mst_i & PSEL_mst_o);
  assign w_slverr   = |(PSLVERR_mst_i & PSEL_mst_o);
  assign w_access   = r_state == S_ACCESS;
  assign w_complete = w_access && w_ready && !TOUT_mst_i;
  assign w_abort    = (r_state == S_SETUP || w_access) &&
                      (TOUT_mst_i || (w_access && !w_ready && r_cnt == CW'(TOUT_CYC - 1)));
  assign BUSY_mst_o = r_state != S_IDLE && !w_complete;
  assign w_accept   = TRANSFER_mst_i && !BUSY_mst_o;
  // Return-data mux driven only by the selected slave, so idle slaves cannot leak onto RDATA
  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++)
      w_rdata = w_rdata | (PSEL_mst_o[k] ? PRDATA_mst_i[k*DATA_WIDTH +: DATA_WIDTH] : '0);
  end
  // Transfer sequencing; completion pulse and a back-to-back accept may share one edge
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_err_late    <= 1'b0;
      DONE_mst_o    <= 1'b0;
      FAIL_mst_o    <= 2'b00;
      RDATA_mst_o   <= '0;
      PADDR_mst_o   <= '0;
      PWRITE_mst_o  <= 1'b0;
      PSEL_mst_o    <= '0;
      PENABLE_mst_o <= 1'b0;
      PWDATA_mst_o  <= '0;
`ifdef APB_PSTRB_EN
      PSTRB_mst_o   <= '0;
`endif
    end else begin
      DONE_mst_o  <= 1'b0;
      FAIL_mst_o  <= 2'b00;
      RDATA_mst_o <= '0;
      if (w_complete) begin
        DONE_mst_o  <= 1'b1;
        FAIL_mst_o  <= {1'b0, w_slverr};
        RDATA_mst_o <= PWRITE_mst_o ? '0 : w_rdata;
      end
      if (w_accept) begin
        PADDR_mst_o   <= ADDR_mst_i;
        PWRITE_mst_o  <= RW_mst_i;
        PWDATA_mst_o  <= WDATA_mst_i;
`ifdef APB_PSTRB_EN
        PSTRB_mst_o   <= RW_mst_i ? STRB_mst_i : '0;
`endif
        PENABLE_mst_o <= 1'b0;
        r_cnt         <= '0;
        if (w_valid) begin
          r_state    <= S_SETUP;
          PSEL_mst_o <= NUM_SLAVES'(1) << w_idx;
        end else begin
          r_state    <= S_ERR;
          PSEL_mst_o <= '0;
          r_err_late <= w_complete;
          if (!w_complete) begin
            DONE_mst_o <= 1'b1;
            FAIL_mst_o <= 2'b10;
          end
        end
      end else if (r_state == S_ERR) begin
        r_state    <= S_IDLE;
        r_err_late <= 1'b0;
        if (r_err_late) begin
          DONE_mst_o <= 1'b1;
          FAIL_mst_o <= 2'b10;
        end
      end else if (w_abort) begin
        r_state       <= S_IDLE;
        PSEL_mst_o    <= '0;
        PENABLE_mst_o <= 1'b0;
        DONE_mst_o    <= 1'b1;
        FAIL_mst_o    <= 2'b11;
      end else if (w_complete) begin
        r_state       <= S_IDLE;
        PSEL_mst_o    <= '0;
        PENABLE_mst_o <= 1'b0;
      end else if (r_state == S_SETUP) begin
        r_state       <= S_ACCESS;
        PENABLE_mst_o <= 1'b1;
      end else if (w_access) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_nsel.sv
// tb_apb_master_nsel: randomized and directed checks of apb_master_nsel against a transaction-age model
module tb_apb_master_nsel;
  localparam int NS = 3;
  localparam int TC = 16;
  logic clk = 1'b0, rst_n;
  logic [31:0] addr, wdata;
  logic rw, tr, tout;
  logic [NS-1:0] pready, pslverr;
  logic [NS*32-1:0] prdata;
  logic busy, done, pwrite, penable;
  logic [1:0] fail;
  logic [31:0] rdata, paddr, pwdata;
  logic [NS-1:0] psel;
`ifdef APB_PSTRB_EN
  logic [3:0] strb = 4'hF, pstrb;
`endif
  int checks = 0, failures = 0;
  bit m_act, m_err, m_late, m_rw, e_done;
  int m_age, m_idx;
  logic [31:0] m_addr, m_wdata, e_rdata;
  logic [1:0] e_fail;

  apb_master_nsel #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NS), .SEL_BITS(2), .TOUT_CYC(TC)) dut (
    .PCLK(clk), .PRESETn(rst_n), .ADDR_mst_i(addr), .RW_mst_i(rw), .TRANSFER_mst_i(tr),
    .WDATA_mst_i(wdata), .TOUT_mst_i(tout), .BUSY_mst_o(busy), .DONE_mst_o(done),
    .FAIL_mst_o(fail), .RDATA_mst_o(rdata), .PADDR_mst_o(paddr), .PWRITE_mst_o(pwrite),
    .PSEL_mst_o(psel), .PENABLE_mst_o(penable), .PWDATA_mst_o(pwdata),
    .PREADY_mst_i(pready), .PSLVERR_mst_i(pslverr),
`ifdef APB_PSTRB_EN
    .STRB_mst_i(strb), .PSTRB_mst_o(pstrb),
`endif
    .PRDATA_mst_i(prdata));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic bit m_busy();
    return m_err || (m_act && !(m_age >= 2 && pready[m_idx] && !tout));
  endfunction

  task automatic m_reset();
    m_act = 0; m_err = 0; m_late = 0; m_age = 0; m_idx = 0;
    e_done = 0; e_fail = 0; e_rdata = 0;
  endtask

  // A transfer is "age" cycles old: age 1 is the setup cycle, age>=2 are access cycles
  task automatic m_update();
    bit b, fin;
    int idx;
    b = m_busy();
    fin = 0;
    e_done = 0; e_fail = 0; e_rdata = 0;
    if (!rst_n) m_reset();
    else begin
      if (m_err) begin
        if (m_late) begin e_done = 1; e_fail = 2; end
        m_err = 0; m_late = 0;
      end else if (m_act) begin
        if (tout || (m_age == TC + 1 && !pready[m_idx])) begin
          m_act = 0; e_done = 1; e_fail = 3;
        end else if (m_age >= 2 && pready[m_idx]) begin
          m_act = 0; fin = 1; e_done = 1; e_fail = {1'b0, pslverr[m_idx]};
          e_rdata = m_rw ? 32'h0 : prdata[m_idx*32 +: 32];
        end else m_age++;
      end
      if (tr && !b) begin
        m_addr = addr; m_rw = rw; m_wdata = wdata; idx = int'(addr[31:30]);
        if (idx < NS) begin m_act = 1; m_age = 1; m_idx = idx; end
        else begin
          m_err = 1;
          if (fin) m_late = 1;
          else begin e_done = 1; e_fail = 2; end
        end
      end
    end
  endtask

  // One clock: check BUSY against current inputs, advance model, check registered outputs
  task automatic step();
    #1 chk("busy", busy, m_busy());
    @(posedge clk);
    m_update();
    @(negedge clk);
    chk("done", done, e_done);
    chk("fail", fail, e_fail);
    chk("rdata", rdata, e_rdata);
    chk("psel", psel, m_act ? NS'(1) << m_idx : NS'(0));
    chk("penable", penable, m_act && m_age >= 2);
    if (m_act) begin
      chk("paddr", paddr, m_addr);
      chk("pwrite", pwrite, m_rw);
      chk("pwdata", pwdata, m_wdata);
    end
  endtask

  task automatic req(input bit t, input logic [31:0] a, input bit w, input logic [31:0] d);
    tr = t; addr = a; rw = w; wdata = d;
  endtask

  initial begin
    int n;
    m_reset();
    rst_n = 0; req(0, 0, 0, 0); tout = 0; pready = 0; pslverr = 0; prdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_psel", psel, 0); chk("rst_done", done, 0); chk("rst_busy", busy, 0);
    chk("rst_paddr", paddr, 0); chk("rst_fail", fail, 0);
    rst_n = 1;
    // Write to slave 1, ready on first access cycle
    req(1, 32'h4000_0010, 1, 32'hDEAD_BEEF); step();
    chk("w_setup_psel", psel, 3'b010); chk("w_setup_pen", penable, 0);
    req(0, 0, 0, 0); pready = 3'b010; step();
    chk("w_acc_pen", penable, 1); chk("w_acc_pwdata", pwdata, 32'hDEAD_BEEF);
    step();
    chk("w_done", done, 1); chk("w_fail", fail, 2'b00); chk("w_psel_off", psel, 0);
    pready = 0; step();
    // Read from slave 0 with three wait states
    prdata = {32'hAAAA_AAAA, 32'h5555_5555, 32'h1234_5678};
    req(1, 32'h0000_0004, 0, 0); step();
    req(0, 0, 0, 0); pready = 0;
    repeat (4) step();
    chk("r_wait_done", done, 0);
    pready = 3'b111; step();
    chk("r_done", done, 1); chk("r_rdata", rdata, 32'h1234_5678);
    pready = 0; step();
    chk("r_rdata_clr", rdata, 0);
    // Decode error: index 3 with three slaves
    req(1, 32'hC000_0000, 0, 0); step();
    chk("de_done", done, 1); chk("de_fail", fail, 2'b10); chk("de_psel", psel, 0);
    req(0, 0, 0, 0); step();
    // Timeout on slave 2
    req(1, 32'h8000_0000, 0, 0); step();
    req(0, 0, 0, 0); pready = 0; n = 0;
    while (!done && n < 40) begin step(); n++; end
    chk("to_cycles", n, 17); chk("to_fail", fail, 2'b11); chk("to_psel", psel, 0);
    step();
    // Back-to-back writes to slave 0 then slave 2
    req(1, 32'h0000_0100, 1, 32'h1111_1111); step();
    pready = 3'b001; step();
    req(1, 32'h8000_0200, 1, 32'h2222_2222); step();
    chk("b2b_done", done, 1); chk("b2b_psel", psel, 3'b100); chk("b2b_pen", penable, 0);
    req(0, 0, 0, 0); pready = 3'b100; step(); step();
    chk("b2b_done2", done, 1);
    pready = 0; step();
    // Slave error on slave 1
    req(1, 32'h4000_0000, 0, 0); step();
    req(0, 0, 0, 0); pready = 3'b010; pslverr = 3'b010; step(); step();
    chk("se_fail", fail, 2'b01);
    pslverr = 0; pready = 0; step();
    // Reset mid-access
    req(1, 32'h4000_0008, 1, 32'h3333_3333); step();
    req(0, 0, 0, 0); step();
    #2 rst_n = 0;
    #1 chk("mr_psel", psel, 0); chk("mr_pen", penable, 0); chk("mr_done", done, 0);
    m_reset();
    @(negedge clk);
    pready = 3'b111; step(); step();
    rst_n = 1; pready = 0; step();
    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      req($urandom_range(3, 0) != 0, $urandom, $urandom_range(1, 0), $urandom);
      tout = $urandom_range(19, 0) == 0;
      pready = NS'($urandom); pslverr = NS'($urandom);
      prdata = {$urandom, $urandom, $urandom};
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
